data_memory: RTL and testbench

//   Byte-addressed data memory for the P4 single-cycle MIPS datapath. Sits directly

---
 rtl/data_memory.sv | 111 +++++++++++
 tb/tb_data_memory.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory for the single-cycle MIPS datapath.
// Combinational load path, read-modify-write store on the rising edge,
// registered store-trace record and a sticky access-fault flag.
module data_memory #(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_pc,
  output logic        fault
);

  localparam logic [2:0]  OP_W   = 3'd0;
  localparam logic [2:0]  OP_HS  = 3'd1;
  localparam logic [2:0]  OP_HU  = 3'd2;
  localparam logic [2:0]  OP_BS  = 3'd3;
  localparam logic [2:0]  OP_BU  = 3'd4;
  localparam logic [31:0] LIMIT  = 32'(4 * DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] widx;
  logic              is_word, is_half, is_byte;
  logic              aligned, legal, commit;
  logic [31:0]       cur, merged;
  logic [3:0]        be;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;

  assign widx    = addr[ADDR_W+1:2];
  assign is_word = (mem_op == OP_W);
  assign is_half = (mem_op == OP_HS) || (mem_op == OP_HU);
  assign is_byte = (mem_op == OP_BS) || (mem_op == OP_BU);
  assign aligned = is_word ? (addr[1:0] == 2'b00) :
                   is_half ? (addr[0] == 1'b0) : 1'b1;
  // is_word/half/byte already excludes ops above 4
  assign legal   = (is_word || is_half || is_byte) && (addr < LIMIT) && aligned;
  assign commit  = mem_we && legal;

  // Out-of-range indices never reach the array: illegal accesses see zero.
  assign cur = legal ? mem[widx] : 32'h0;

  // Per-byte-lane write enable and merge; the half store feeds the low two
  // bytes of wdata to whichever half is addressed, the byte store feeds byte 0.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign be[k] = is_word ||
                   (is_half && (addr[1] == k[1])) ||
                   (is_byte && (addr[1:0] == k[1:0]));
    assign merged[8*k +: 8] = !be[k] ? cur[8*k +: 8] :
                              is_word ? wdata[8*k +: 8] :
                              is_half ? wdata[8*(k%2) +: 8] : wdata[7:0];
  end

  assign half_sel = addr[1] ? cur[31:16] : cur[15:0];
  assign byte_sel = cur[8*addr[1:0] +: 8];

  // Load extraction and sign/zero extension; illegal accesses read as zero.
  always_comb begin
    rdata = 32'h0;
    if (legal) begin
      unique case (mem_op)
        OP_W:    rdata = cur;
        OP_HS:   rdata = {{16{half_sel[15]}}, half_sel};
        OP_HU:   rdata = {16'h0, half_sel};
        OP_BS:   rdata = {{24{byte_sel[7]}}, byte_sel};
        OP_BU:   rdata = {24'h0, byte_sel};
        default: rdata = 32'h0;
      endcase
    end
  end

  // Storage: cleared on reset, merged word written on a legal store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (commit) begin
      mem[widx] <= merged;
    end
  end

  // Trace record of the last committed store plus the sticky fault flag.
  // Idle cycles drive mem_op=0/addr=0, which is legal, so any illegal
  // access (load or store) latches the fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid <= 1'b0;
      wr_addr  <= 32'h0;
      wr_data  <= 32'h0;
      wr_pc    <= 32'h0;
      fault    <= 1'b0;
    end else begin
      wr_valid <= commit;
      if (commit) begin
        wr_addr <= {addr[31:2], 2'b00};
        wr_data <= merged;
        wr_pc   <= pc;
      end
      if (!legal) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, load extension, partial stores,
// trace pulses, illegal accesses and same-cycle store/load ordering.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rdata, wr_addr, wr_data, wr_pc;
  logic        wr_valid, fault;

  int nvec = 0;
  int nerr = 0;

  data_memory dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .pc(pc), .rdata(rdata), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic we, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] p);
    mem_we = we; mem_op = op; addr = a; wdata = d; pc = p;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drv(1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // power-on reset
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    chk("rst_fault",    {31'h0, fault},    32'h0);
    chk("rst_lw0",      rdata,             32'h0);

    // word store then asynchronous reset mid-cycle
    drv(1'b1, 3'd0, 32'h0, 32'h1234_5678, 32'h100);
    tick;
    chk("sw0_valid", {31'h0, wr_valid}, 32'h1);
    chk("sw0_data",  wr_data,           32'h1234_5678);
    chk("sw0_pc",    wr_pc,             32'h100);
    idle;
    chk("lw0",       rdata,             32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_lw0",   rdata,             32'h0);
    chk("arst_valid", {31'h0, wr_valid}, 32'h0);
    chk("arst_addr",  wr_addr,           32'h0);
    chk("arst_data",  wr_data,           32'h0);
    chk("arst_pc",    wr_pc,             32'h0);
    chk("arst_fault", {31'h0, fault},    32'h0);
    // store presented while reset is held across the edge is lost
    drv(1'b1, 3'd0, 32'h4, 32'hDEAD_BEEF, 32'h104);
    tick;
    reset = 1'b0;
    idle;
    drv(1'b0, 3'd0, 32'h4, 32'h0, 32'h0);
    chk("rst_store_lost", rdata, 32'h0);
    tick;

    // load extension
    drv(1'b1, 3'd0, 32'h10, 32'hAABB_CCDD, 32'h200);
    tick;
    chk("sw10_addr", wr_addr, 32'h10);
    drv(1'b0, 3'd3, 32'h10, 32'h0, 32'h0); chk("lb10",  rdata, 32'hFFFF_FFDD);
    drv(1'b0, 3'd4, 32'h13, 32'h0, 32'h0); chk("lbu13", rdata, 32'h0000_00AA);
    drv(1'b0, 3'd1, 32'h12, 32'h0, 32'h0); chk("lh12",  rdata, 32'hFFFF_AABB);
    drv(1'b0, 3'd2, 32'h10, 32'h0, 32'h0); chk("lhu10", rdata, 32'h0000_CCDD);
    drv(1'b0, 3'd4, 32'h11, 32'h0, 32'h0); chk("lbu11", rdata, 32'h0000_00CC);
    tick;

    // back-to-back partial stores
    drv(1'b1, 3'd0, 32'h20, 32'h0, 32'h300);
    tick;
    chk("bb1_valid", {31'h0, wr_valid}, 32'h1);
    drv(1'b1, 3'd3, 32'h21, 32'h1234_5680, 32'h304);
    tick;
    chk("bb2_valid", {31'h0, wr_valid}, 32'h1);
    chk("bb2_data",  wr_data,           32'h0000_8000);
    chk("bb2_addr",  wr_addr,           32'h20);
    drv(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, 32'h308);
    tick;
    chk("bb3_valid", {31'h0, wr_valid}, 32'h1);
    chk("bb3_data",  wr_data,           32'hBEEF_8000);
    chk("bb3_pc",    wr_pc,             32'h308);
    drv(1'b0, 3'd0, 32'h20, 32'h0, 32'h0);
    chk("lw20", rdata, 32'hBEEF_8000);
    tick;
    chk("idle_valid", {31'h0, wr_valid}, 32'h0);
    chk("idle_hold",  wr_data,           32'hBEEF_8000);
    chk("pre_fault",  {31'h0, fault},    32'h0);

    // illegal stores and out-of-range load
    drv(1'b1, 3'd0, 32'h22, 32'hFFFF_FFFF, 32'h400);
    chk("mis_sw_rdata", rdata, 32'h0);
    tick;
    chk("mis_sw_valid", {31'h0, wr_valid}, 32'h0);
    chk("mis_sw_fault", {31'h0, fault},    32'h1);
    drv(1'b1, 3'd1, 32'h31, 32'hFFFF_FFFF, 32'h404);
    tick;
    chk("mis_sh_valid", {31'h0, wr_valid}, 32'h0);
    chk("mis_hold_pc",  wr_pc,             32'h308);
    drv(1'b0, 3'd0, 32'h20, 32'h0, 32'h0); chk("lw20_kept", rdata, 32'hBEEF_8000);
    drv(1'b0, 3'd0, 32'h30, 32'h0, 32'h0); chk("lw30_kept", rdata, 32'h0);
    drv(1'b0, 3'd0, 32'h3000, 32'h0, 32'h0); chk("lw3000", rdata, 32'h0);
    drv(1'b0, 3'd0, 32'h2FFC, 32'h0, 32'h0); chk("lw2ffc", rdata, 32'h0);
    idle;
    tick; tick;
    chk("fault_sticky", {31'h0, fault}, 32'h1);

    // highest legal word is writable
    drv(1'b1, 3'd0, 32'h2FFC, 32'hCAFE_F00D, 32'h500);
    tick;
    chk("top_valid", {31'h0, wr_valid}, 32'h1);
    drv(1'b0, 3'd0, 32'h2FFC, 32'h0, 32'h0); chk("lw2ffc_new", rdata, 32'hCAFE_F00D);

    // same-cycle store/load sees old data
    drv(1'b1, 3'd0, 32'h40, 32'h1111_2222, 32'h600);
    chk("raw_old", rdata, 32'h0);
    tick;
    drv(1'b0, 3'd0, 32'h40, 32'h0, 32'h0);
    chk("raw_new", rdata, 32'h1111_2222);

    // illegal op code after a fresh reset
    #2; reset = 1'b1; #1; reset = 1'b0;
    chk("rst2_fault", {31'h0, fault}, 32'h0);
    drv(1'b1, 3'd5, 32'h44, 32'hFFFF_FFFF, 32'h700);
    chk("op5_rdata", rdata, 32'h0);
    tick;
    chk("op5_valid", {31'h0, wr_valid}, 32'h0);
    chk("op5_fault", {31'h0, fault},    32'h1);
    drv(1'b0, 3'd0, 32'h44, 32'h0, 32'h0);
    chk("op5_nowrite", rdata, 32'h0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
